// File: rtl/comb_sweep_driver.sv
`default_nettype none
// ============================================================================
//  Module   : comb_sweep_driver
//  Purpose  : Exhaustive stimulus generator and checker for a purely
//             combinational comb_test instance. Walks {src3,src2,src1}
//             through every value, compares out1..out5 against an internal
//             model in the same cycle and reports pass/fail, a saturating
//             error count and the first failing vector.
//  Ports    : clk, rst_n (sync, active low), start, abort
//             src1..src3  registered stimulus to the DUT
//             out1..out5  DUT responses
//             busy/done   sweep status, pass valid while done
//             err_count   mismatching vectors, saturating
//             first_fail  {src3,src2,src1} of first mismatch, 0 if none
//  Revision : 1.0  initial release
// ============================================================================
module comb_sweep_driver #(
   parameter int size  = 1,
   parameter int CNT_W = 16
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                start,
   input  logic                abort,
   output logic [size-1:0]     src1,
   output logic [size-1:0]     src2,
   output logic [size-1:0]     src3,
   input  logic [size-1:0]     out1,
   input  logic [size-1:0]     out2,
   input  logic [size-1:0]     out3,
   input  logic [size-1:0]     out4,
   input  logic [size-1:0]     out5,
   output logic                busy,
   output logic                done,
   output logic                pass,
   output logic [CNT_W-1:0]    err_count,
   output logic [3*size-1:0]   first_fail
);

   localparam int VW = 3 * size;

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_RUN  = 2'd1;
   localparam logic [1:0] ST_DONE = 2'd2;

   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   logic [1:0]      state;
   logic [VW-1:0]   vec;

   logic [2:0]      lsbs;
   logic [size-1:0] m1, m2, m3, m4, m5;
   logic            mismatch;
   logic            last_vec;

   // The vector counter is the stimulus register itself; src1 is the LSB field.
   assign {src3, src2, src1} = vec;

   assign busy     = (state == ST_RUN);
   assign done     = (state == ST_DONE);
   assign last_vec = &vec;

   // Reference model of comb_test evaluated on the currently applied vector.
   always_comb begin
      lsbs = {src3[0], src2[0], src1[0]};
      m1   = src1;
      m2   = src2;
      m3   = src1;
      m4   = src2;
      m5   = src1;
      if (src1 < src2) begin
         m1 = (lsbs == 3'd1) ? src3 : src1;
         m2 = (lsbs == 3'd1) ? src3 : src2;
         m3 = (lsbs == 3'd3) ? '0   : src2;
         m4 = (lsbs == 3'd1) ? src3 : ((lsbs == 3'd3) ? '0 : src1);
         m5 = src3;
      end
   end

   // Case inequality so that an X/Z response bit is treated as a mismatch.
   assign mismatch = (out1 !== m1) || (out2 !== m2) || (out3 !== m3) ||
                     (out4 !== m4) || (out5 !== m5);

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state      <= ST_IDLE;
         vec        <= '0;
         pass       <= 1'b0;
         err_count  <= '0;
         first_fail <= '0;
      end else begin
         case (state)
            ST_IDLE, ST_DONE: begin
               if (start) begin
                  state      <= ST_RUN;
                  vec        <= '0;
                  pass       <= 1'b0;
                  err_count  <= '0;
                  first_fail <= '0;
               end
            end
            ST_RUN: begin
               if (abort) begin
                  // The compare of this cycle is dropped; the tally so far stays.
                  state <= ST_IDLE;
                  vec   <= '0;
               end else begin
                  if (mismatch) begin
                     if (err_count != CNT_MAX)
                        err_count <= err_count + 1'b1;
                     if (err_count == '0)
                        first_fail <= vec;
                  end
                  if (last_vec) begin
                     state <= ST_DONE;
                     pass  <= (err_count == '0) && !mismatch;
                  end else begin
                     vec <= vec + 1'b1;
                  end
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule
`default_nettype wire
